// File: rtl/logic_unit_pkg.sv
// Shared operation encodings for the buffered bitwise logic unit.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

endpackage

// File: rtl/logic_op_nbit.sv
// Purely combinational bitwise operation selected by op; b is unused for NOT and PASS.
module logic_op_nbit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = a;
    case (op_e'(op))
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_nbit.sv
// Bitwise logic unit with a DEPTH-entry in-order result buffer and valid/ready handshakes.
// Optional zero/negative flags are enabled by defining LOGIC_UNIT_FLAGS_EN.
module logic_unit_nbit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zr,
  output logic             out_ng,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int ENTRY_W = WIDTH + 2;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [WIDTH-1:0]   result;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_q [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               push, pop;

  logic_op_nbit #(.WIDTH(WIDTH)) u_op (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (result)
  );

`ifdef LOGIC_UNIT_FLAGS_EN
  assign entry_in = {(result == '0), result[WIDTH-1], result};
`else
  assign entry_in = result;
`endif

  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  // No push is taken during a reset cycle so the buffer stays empty.
  assign push      = in_valid && in_ready && rst_n;
  assign pop       = out_valid && out_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [ENTRY_W-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        entry_reg <= entry_in;
      end
    end
    assign entry_q[gi] = entry_reg;
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  assign head     = out_valid ? entry_q[rd_ptr_reg] : '0;
  assign out_data = head[WIDTH-1:0];
`ifdef LOGIC_UNIT_FLAGS_EN
  assign out_zr   = head[WIDTH+1];
  assign out_ng   = head[WIDTH];
`endif

endmodule

// File: tb/tb_logic_unit_nbit.sv
// Directed self-checking bench for logic_unit_nbit (WIDTH=16, DEPTH=2).
module tb_logic_unit_nbit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic        out_zr, out_ng;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] op_exp [8] = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0,
                              16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};

  logic_unit_nbit #(.WIDTH(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zr    (out_zr),
    .out_ng    (out_ng),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  // One beat into an empty buffer with out_ready=1: visible one edge later, gone the next.
  task automatic single_beat(input string tag, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] exp);
    drive(1'b1, op, a, b);
    step();
    drive(1'b0, 3'b000, 16'h0000, 16'h0000);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_data"},  64'(out_data),  64'(exp));
`ifdef LOGIC_UNIT_FLAGS_EN
    chk({tag, "_zr"}, 64'(out_zr), 64'(exp == 16'h0000));
    chk({tag, "_ng"}, 64'(out_ng), 64'(exp[15]));
`endif
    step();
    chk({tag, "_drained"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 16'h0000, 16'h0000);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_data",  64'(out_data),  64'(0));

    single_beat("not_0000", 3'b000, 16'h0000, 16'h1234, 16'hFFFF);
    single_beat("not_ffff", 3'b000, 16'hFFFF, 16'h0000, 16'h0000);
    single_beat("not_ab1a", 3'b000, 16'hAB1A, 16'h0000, 16'h54E5);

    for (int i = 0; i < 8; i++) begin
      single_beat($sformatf("op%0d", i), 3'(i), 16'hF0F0, 16'hFF00, op_exp[i]);
    end

    // Backpressure: two beats fill the buffer, third waits until a slot frees.
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 16'h1234, 16'h00FF);
    step();
    chk("bp_head1", 64'(out_data), 64'h0034);
    chk("bp_rdy1",  64'(in_ready), 64'(1));
    drive(1'b1, 3'b010, 16'h1200, 16'h0034);
    step();
    chk("bp_rdy_full", 64'(in_ready), 64'(0));
    chk("bp_head2",    64'(out_data), 64'h0034);
    drive(1'b1, 3'b011, 16'hFFFF, 16'h0F0F);
    step();
    chk("bp_rdy_hold", 64'(in_ready), 64'(0));
    chk("bp_stable",   64'(out_data), 64'h0034);
    out_ready = 1'b1;
    step();
    chk("bp_second",   64'(out_data), 64'h1234);
    chk("bp_rdy_free", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 3'b000, 16'h0000, 16'h0000);
    chk("bp_third",    64'(out_data),  64'hF0F0);
    chk("bp_third_v",  64'(out_valid), 64'(1));
    step();
    chk("bp_empty",    64'(out_valid), 64'(0));

    // Streaming: one result per cycle, buffer never fills.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'b011, 16'(i * 16'h0101), 16'h5A5A);
      step();
      chk($sformatf("st%0d_data", i), 64'(out_data), 64'((i * 16'h0101) ^ 16'h5A5A));
      chk($sformatf("st%0d_rdy", i),  64'(in_ready), 64'(1));
    end
    drive(1'b0, 3'b000, 16'h0000, 16'h0000);
    step();
    chk("st_drained", 64'(out_valid), 64'(0));

    // Mid-stream reset discards two buffered results and a beat offered during reset.
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 16'hBEEF, 16'h0000);
    step();
    drive(1'b1, 3'b111, 16'hCAFE, 16'h0000);
    step();
    chk("mr_full", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'b111, 16'h1111, 16'h0000);
    step();
    rst_n = 1'b1;
    drive(1'b0, 3'b000, 16'h0000, 16'h0000);
    chk("mr_out_valid", 64'(out_valid), 64'(0));
    chk("mr_in_ready",  64'(in_ready),  64'(1));
    chk("mr_out_data",  64'(out_data),  64'(0));
    step();
    chk("mr_still_empty", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_nbit.md
LOGIC_UNIT_NBIT -- requirements
Module: logic_unit_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the data width in bits (legal 1..64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning the output buffer entries (legal 2..8, power of two).
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  the reset; synchronous, active-low.
REQ-005 SHALL have in_valid  input  1  the operand beat valid.
REQ-006 SHALL have in_ready  output  1  the unit can accept a beat this cycle.
REQ-007 SHALL have in_op  input  3  the operation select.
REQ-008 SHALL have in_a, in_b  input  WIDTH  the operands.
REQ-009 SHALL have out_valid  output  1  out_data holds a result.
REQ-010 SHALL have out_ready  input  1  the consumer takes the result this cycle.
REQ-011 SHALL have out_data  output  WIDTH  the result.
REQ-012 SHALL have out_zr, out_ng  output  1 each  the flags; present only under LOGIC_UNIT_FLAGS_EN.

Function
REQ-013 SHALL decode in_op as 000 NOT a, 001 a AND b, 010 a OR b, 011 a XOR b, 100 NAND, 101 NOR, 110 XNOR, 111 PASS a; all operations bitwise over WIDTH bits; in_b ignored for 000 and 111.
REQ-014 SHALL accept a beat on a rising edge where in_valid && in_ready, computing the result combinationally and writing it into the buffer tail on that edge.
REQ-015 SHALL have latency 1: a beat accepted into an empty buffer on edge N is presented with out_valid=1 from edge N to edge N+1.
REQ-016 SHALL retire the head entry on a rising edge where out_valid && out_ready; results leave in acceptance order.
REQ-017 SHALL drive in_ready = (count < DEPTH), independent of out_ready (no combinational ready path).
REQ-018 SHALL drive out_valid = (count != 0); out_data shows the head entry and is held stable while out_valid && !out_ready.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and sustain one beat per cycle; when count==DEPTH with out_ready=1, in_ready stays 0 that cycle (no push when full).
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL ignore in_op/in_a/in_b whenever in_valid=0 or in_ready=0.

Reset
REQ-022 SHALL, on rising edge with rst_n=0, clear count and both pointers; the next cycle has out_valid=0, in_ready=1.
REQ-023 SHALL drive out_data=0 and (if enabled) out_zr=0, out_ng=0 while count==0, including after reset.
REQ-024 SHALL discard all buffered results when reset is asserted mid-stream; any beat presented in a reset cycle is not accepted.

Configuration
REQ-025 SHALL, with LOGIC_UNIT_FLAGS_EN defined, store per entry zr=(result==0) and ng=result[WIDTH-1], presented with out_data.
REQ-026 SHALL, without LOGIC_UNIT_FLAGS_EN, omit out_zr/out_ng ports and flag storage; data behaviour identical.

Structure
REQ-027 SHALL place op encodings (OP_NOT..OP_PASS) and the op-width constant in shared package logic_unit_pkg.
REQ-028 SHALL isolate the combinational operation in sub-module logic_op_nbit (WIDTH parameter, op/a/b in, result out); buffer and handshake stay in the top.

Verification
REQ-029 SHALL cover: reset then in_op=000, in_a=16'h0000, one beat -> next cycle out_valid=1, out_data=16'hFFFF, zr=0, ng=1.
REQ-030 SHALL cover: in_op=000, in_a=16'hFFFF -> out_data=16'h0000, zr=1, ng=0; in_op=000, in_a=16'hAB1A -> out_data=16'h54E5.
REQ-031 SHALL cover: all eight ops with a=16'hF0F0, b=16'hFF00 -> 0F0F, F000, FFF0, 0FF0, 0FFF, 000F, F00F, F0F0.
REQ-032 SHALL cover: out_ready=0, three back-to-back beats -> two accepted, in_ready=0 after second, out_data stable; release out_ready -> results in order, third beat accepted next cycle.
REQ-033 SHALL cover: continuous in_valid and out_ready=1 for 20 beats -> one result per cycle, count never exceeds 1.
REQ-034 SHALL cover: rst_n=0 with two entries buffered -> next cycle out_valid=0, in_ready=1, out_data=0.
